// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: opcodes, funct/REGIMM codes, control-word layout, queue types.
package decode_queue_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REGW  = 5;
    localparam int unsigned CTRLW = 16;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // REGIMM rt codes
    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    // Control-word bit positions; bits [3:0] hold the ALU operation
    localparam int unsigned C_REG_WRITE = 15;
    localparam int unsigned C_MEM_READ  = 14;
    localparam int unsigned C_MEM_WRITE = 13;
    localparam int unsigned C_MEM_TO_REG = 12;
    localparam int unsigned C_BRANCH    = 11;
    localparam int unsigned C_JUMP      = 10;
    localparam int unsigned C_LINK      = 9;
    localparam int unsigned C_REG_DST   = 8;
    localparam int unsigned C_ZERO_EXT  = 7;
    localparam int unsigned C_ALU_IMM   = 6;
    localparam int unsigned C_SHIFT_VAR = 5;
    localparam int unsigned C_OVF_TRAP  = 4;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_SLTU = 4'h7;
    localparam logic [3:0] ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SRL  = 4'h9;
    localparam logic [3:0] ALU_SRA  = 4'hA;
    localparam logic [3:0] ALU_LUI  = 4'hB;

    typedef enum logic {NORMAL, DSLOT} decq_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } decq_entry_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch, issue and redirect signals of the decode queue.
interface decode_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    logic            in_valid;
    logic [31:0]     in_pc;
    logic [31:0]     in_instr;
    logic            in_ready;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     vs;
    logic [31:0]     vt;
    logic [31:0]     out_pc;
    logic            out_is_dslot;
    logic [15:0]     controlD;
    logic [4:0]      rsD;
    logic [4:0]      rtD;
    logic [4:0]      rdD;
    logic [4:0]      shamtD;
    logic [31:0]     immD;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic [CNTW-1:0] count;

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready, vs, vt,
        output in_ready, out_valid, out_pc, out_is_dslot, controlD,
               rsD, rtD, rdD, shamtD, immD, redirect_valid, redirect_pc, count
    );

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready, vs, vt,
        input  in_ready, out_valid, out_pc, out_is_dslot, controlD,
               rsD, rtD, rdD, shamtD, immD, redirect_valid, redirect_pc, count
    );
endinterface

// File: rtl/decode_queue_core.sv
// Combinational decoder for the queue head: control word, fields, immediate, CTI resolution.
module decode_queue_core
    import decode_queue_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] vs_i,
    input  logic [31:0] vt_i,
    output logic [15:0] control_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  shamt_o,
    output logic [31:0] imm_o,
    output logic        taken_o,
    output logic [31:0] target_o
);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm16;
    logic [31:0] sext;
    logic [31:0] pc4;
    logic [31:0] pc8;
    logic [3:0]  alu;

    assign op    = instr_i[31:26];
    assign fn    = instr_i[5:0];
    assign imm16 = instr_i[15:0];
    assign sext  = {{16{imm16[15]}}, imm16};
    assign pc4   = pc_i + 32'd4;
    assign pc8   = pc_i + 32'd8;
    assign rs_o  = instr_i[25:21];
    assign rt_o  = instr_i[20:16];

    // Instruction decode; rd_o is the destination register (rt for I-type, 31 for links)
    always_comb begin
        control_o = '0;
        alu       = ALU_ADD;
        rd_o      = instr_i[20:16];
        shamt_o   = instr_i[10:6];
        imm_o     = sext;
        taken_o   = 1'b0;
        target_o  = pc4 + (sext << 2);
        unique case (op)
            OP_SPECIAL: begin
                control_o[C_REG_WRITE] = 1'b1;
                control_o[C_REG_DST]   = 1'b1;
                rd_o                   = instr_i[15:11];
                unique case (fn)
                    FN_SLL:  alu = ALU_SLL;
                    FN_SRL:  alu = ALU_SRL;
                    FN_SRA:  alu = ALU_SRA;
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        alu = (fn == FN_SLLV) ? ALU_SLL : ((fn == FN_SRLV) ? ALU_SRL : ALU_SRA);
                        control_o[C_SHIFT_VAR] = 1'b1;
                        shamt_o = vs_i[4:0];
                    end
                    FN_JR: begin
                        control_o = '0;
                        control_o[C_JUMP] = 1'b1;
                        taken_o  = 1'b1;
                        target_o = vs_i;
                    end
                    FN_JALR: begin
                        control_o[C_JUMP] = 1'b1;
                        control_o[C_LINK] = 1'b1;
                        imm_o    = pc8;
                        taken_o  = 1'b1;
                        target_o = vs_i;
                    end
                    FN_ADD:  begin alu = ALU_ADD; control_o[C_OVF_TRAP] = 1'b1; end
                    FN_ADDU: alu = ALU_ADD;
                    FN_SUB:  begin alu = ALU_SUB; control_o[C_OVF_TRAP] = 1'b1; end
                    FN_SUBU: alu = ALU_SUB;
                    FN_AND:  alu = ALU_AND;
                    FN_OR:   alu = ALU_OR;
                    FN_XOR:  alu = ALU_XOR;
                    FN_NOR:  alu = ALU_NOR;
                    FN_SLT:  alu = ALU_SLT;
                    FN_SLTU: alu = ALU_SLTU;
                    default: control_o = '0;
                endcase
            end
            OP_REGIMM: begin
                control_o[C_BRANCH] = 1'b1;
                unique case (instr_i[20:16])
                    RT_BLTZ: taken_o = vs_i[31];
                    RT_BGEZ: taken_o = ~vs_i[31];
                    RT_BLTZAL, RT_BGEZAL: begin
                        taken_o = (instr_i[16]) ? ~vs_i[31] : vs_i[31];
                        control_o[C_REG_WRITE] = 1'b1;
                        control_o[C_LINK]      = 1'b1;
                        rd_o  = 5'd31;
                        imm_o = pc8;
                    end
                    default: control_o = '0;
                endcase
            end
            OP_J, OP_JAL: begin
                control_o[C_JUMP] = 1'b1;
                taken_o  = 1'b1;
                target_o = {pc4[31:28], instr_i[25:0], 2'b00};
                if (op == OP_JAL) begin
                    control_o[C_REG_WRITE] = 1'b1;
                    control_o[C_LINK]      = 1'b1;
                    rd_o  = 5'd31;
                    imm_o = pc8;
                end
            end
            OP_BEQ:  begin control_o[C_BRANCH] = 1'b1; taken_o = (vs_i == vt_i); end
            OP_BNE:  begin control_o[C_BRANCH] = 1'b1; taken_o = (vs_i != vt_i); end
            OP_BLEZ: begin control_o[C_BRANCH] = 1'b1; taken_o = vs_i[31] | (vs_i == '0); end
            OP_BGTZ: begin control_o[C_BRANCH] = 1'b1; taken_o = ~vs_i[31] & (vs_i != '0); end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                control_o[C_REG_WRITE] = 1'b1;
                control_o[C_ALU_IMM]   = 1'b1;
                unique case (op)
                    OP_ADDI:  begin alu = ALU_ADD; control_o[C_OVF_TRAP] = 1'b1; end
                    OP_SLTI:  alu = ALU_SLT;
                    OP_SLTIU: alu = ALU_SLTU;
                    OP_ANDI:  alu = ALU_AND;
                    OP_ORI:   alu = ALU_OR;
                    OP_XORI:  alu = ALU_XOR;
                    OP_LUI:   alu = ALU_LUI;
                    default:  alu = ALU_ADD;
                endcase
                if (op == OP_ANDI || op == OP_ORI || op == OP_XORI) begin
                    control_o[C_ZERO_EXT] = 1'b1;
                    imm_o = {16'h0, imm16};
                end
                if (op == OP_LUI) imm_o = {imm16, 16'h0};
            end
            OP_LW: begin
                control_o[C_REG_WRITE]  = 1'b1;
                control_o[C_MEM_READ]   = 1'b1;
                control_o[C_MEM_TO_REG] = 1'b1;
                control_o[C_ALU_IMM]    = 1'b1;
            end
            OP_SW: begin
                control_o[C_MEM_WRITE] = 1'b1;
                control_o[C_ALU_IMM]   = 1'b1;
            end
            default: control_o = '0;
        endcase
        control_o[3:0] = alu;
    end
endmodule

// File: rtl/decode_queue.sv
// Decode stage: instruction queue, head decode, delay-slot FSM and fetch redirect.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    decode_queue_if.slave bus
);
    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);

    decq_entry_t     mem_q [DEPTH];
    logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNTW-1:0] count_q, count_d;
    decq_state_t     state_q, state_d;
    logic [31:0]     target_q, target_d;
    logic            redir_valid_q, redir_valid_d;
    logic [31:0]     redir_pc_q, redir_pc_d;

    logic            out_valid_c, in_ready_c, push_c, pop_c, wr_en_c;
    decq_entry_t     head_e;
    logic [15:0]     ctrl_c;
    logic [4:0]      rs_c, rt_c, rd_c, sh_c;
    logic [31:0]     imm_c, target_c;
    logic            taken_c;

    assign out_valid_c = (count_q != '0);
    assign in_ready_c  = (count_q < CNTW'(DEPTH)) & ~redir_valid_q;
    assign push_c      = bus.in_valid & in_ready_c;
    assign pop_c       = out_valid_c & bus.out_ready;
    assign head_e      = mem_q[head_q];

    decode_queue_core u_core (
        .instr_i   (head_e.instr),
        .pc_i      (head_e.pc),
        .vs_i      (bus.vs),
        .vt_i      (bus.vt),
        .control_o (ctrl_c),
        .rs_o      (rs_c),
        .rt_o      (rt_c),
        .rd_o      (rd_c),
        .shamt_o   (sh_c),
        .imm_o     (imm_c),
        .taken_o   (taken_c),
        .target_o  (target_c)
    );

    // Head outputs are forced to zero while the queue is empty
    assign bus.in_ready       = in_ready_c;
    assign bus.out_valid      = out_valid_c;
    assign bus.out_pc         = out_valid_c ? head_e.pc : '0;
    assign bus.out_is_dslot   = out_valid_c & (state_q == DSLOT);
    assign bus.controlD       = out_valid_c ? ctrl_c : '0;
    assign bus.rsD            = out_valid_c ? rs_c : '0;
    assign bus.rtD            = out_valid_c ? rt_c : '0;
    assign bus.rdD            = out_valid_c ? rd_c : '0;
    assign bus.shamtD         = out_valid_c ? sh_c : '0;
    assign bus.immD           = out_valid_c ? imm_c : '0;
    assign bus.redirect_valid = redir_valid_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.count          = count_q;

    // Next-state: flush beats delay-slot squash, which beats ordinary push/pop
    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        target_d      = target_q;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        wr_en_c       = 1'b0;
        if (bus.flush) begin
            state_d  = NORMAL;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            target_d = '0;
        end else begin
            unique case (state_q)
                DSLOT: begin
                    if (pop_c) begin
                        state_d       = NORMAL;
                        head_d        = '0;
                        tail_d        = '0;
                        count_d       = '0;
                        redir_valid_d = 1'b1;
                        redir_pc_d    = target_q;
                    end
                end
                default: begin
                    if (pop_c && taken_c) begin
                        state_d  = DSLOT;
                        target_d = target_c;
                    end
                end
            endcase
            if (!(state_q == DSLOT && pop_c)) begin
                if (push_c) begin
                    wr_en_c = 1'b1;
                    tail_d  = (tail_q == PTRW'(DEPTH - 1)) ? '0 : tail_q + PTRW'(1);
                end
                if (pop_c) begin
                    head_d = (head_q == PTRW'(DEPTH - 1)) ? '0 : head_q + PTRW'(1);
                end
                if (push_c && !pop_c) count_d = count_q + CNTW'(1);
                else if (!push_c && pop_c) count_d = count_q - CNTW'(1);
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= NORMAL;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            target_q      <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            target_q      <= target_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    // Entry storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[tail_q] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Parametrised decode stage with an internal instruction queue.
- Sits between fetch and issue; buffers up to DEPTH {pc, instr} pairs from fetch.
- Decodes the head entry combinationally.
- Resolves control transfers at the head and enforces the MIPS delay slot: the instruction after a taken CTI is released, then wrong-path entries are squashed.
- Emits a one-cycle registered redirect to fetch.

Parameters:
DEPTH, 4, queue entries; any integer >= 2, not required to be a power of two.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  fetch offers an entry
in_pc  in  32  pc of offered instruction
in_instr  in  32  offered instruction word
in_ready  out  1  queue accepts this cycle
flush  in  1  exception/ERET flush from commit, highest priority
out_valid  out  1  head entry valid
out_ready  in  1  issue consumes head (low = hazard stall)
vs  in  32  forwarded rs value for head entry
vt  in  32  forwarded rt value for head entry
out_pc  out  32  head pc
out_is_dslot  out  1  head is a delay-slot instruction
controlD  out  16  control word of head (team control-word layout)
rsD, rtD, rdD, shamtD  out  5 each  register/shamt fields (shamtD = vs[4:0] for variable shifts)
immD  out  32  immediate / link value (pc+8 for link instructions)
redirect_valid  out  1  one-cycle redirect pulse to fetch
redirect_pc  out  32  redirect target
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset: count=0, head=tail=0, state=NORMAL, redirect_valid=0, redirect_pc=0. Queue contents are don't-care.
- Push fires when in_valid & in_ready. Pop fires when out_valid & out_ready.
- Pointers wrap explicitly from DEPTH-1 to 0.
- in_ready = (count < DEPTH) & ~redirect_valid.
  - Full with a simultaneous pop: push is NOT accepted; there is no bypass.
  - Simultaneous push and pop when not full: count is unchanged.
- out_valid = (count != 0).
- While out_valid=0, controlD, rsD, rtD, rdD, shamtD and immD are driven to 0. out_pc is driven to 0. out_is_dslot=0.
- Latency: an entry pushed at edge N is visible at the head from cycle N+1 at the earliest. There is no same-cycle pass-through.
- CTI detection on the head:
  - Taken condition: conditional branch taken (BEQ, BNE, BGTZ, BLEZ, BLTZ, BGEZ, BLTZAL, BGEZAL using vs/vt), or J, JAL, JR, JALR.
  - Targets: branch = pc+4+(sext(imm)<<2); J/JAL = {(pc+4)[31:28], index, 2'b00}; JR/JALR = vs.
- State machine:
  - NORMAL:
    - Pop of a taken CTI latches target_q and goes to DSLOT.
    - Pop of a not-taken branch stays in NORMAL.
  - DSLOT:
    - Head, when present, is flagged out_is_dslot=1.
    - If the queue is empty, wait; pushes are still accepted.
    - On the delay-slot pop edge: count, head and tail clear to 0, and any same-cycle push is discarded. redirect_valid<=1 and redirect_pc<=target_q. Return to NORMAL.
  - The redirect pulse is high for exactly one cycle. in_ready=0 during that cycle.
- A CTI sitting in a delay slot is treated as a non-CTI for redirect purposes; nested CTIs are not supported architecturally.
- flush=1:
  - At the next edge: queue cleared, state=NORMAL, target_q discarded, redirect_valid<=0. Same-cycle push and pop are ignored.
  - Dominates a coinciding delay-slot redirect.
- Reset asserted mid-DSLOT: identical to the reset values above; no redirect is emitted.
- Stall (out_ready=0) holds the head and all outputs stable. vs/vt may change and re-evaluate the branch decision combinationally.

Decomposition:
- Shared package (cpu_pkg / icode header): opcode, funct and REGIMM-rt constants; control-word field positions; decq_state_t enum {NORMAL, DSLOT}.
- One combinational sub-module, decode_core: takes (instr, pc, vs, vt) and produces (controlD, fields, immD, taken, target).
- decode_queue owns storage, pointers, state and redirect registers.

Test Plan:
- Push addiu $2,$1,5 (0x24220005) @pc 0xBFC00000, out_ready=1 → next cycle out_valid=1, controlD=0x8040, rsD=1, rdD=2, immD=5; popped; count returns to 0.
- Fill DEPTH=4 with out_ready=0 → in_ready=0 at count=4. Fifth push rejected even with a concurrent pop. Drain order equals push order across pointer wrap.
- beq $1,$2,+4 (0x10220004) @0xBFC00000 with vs=vt=7, then nop@0xBFC00004 and nop@0xBFC00008 queued → nop@04 pops with out_is_dslot=1. Next cycle redirect_valid=1, redirect_pc=0xBFC00014, count=0. Entry @08 is never issued.
- j 0x0BF00010 @0xBFC00000 popped with the delay slot not yet fetched → holds DSLOT. Delay slot pushed later and popped → redirect_pc=0xBFC00040, one-cycle pulse.
- beq with vs≠vt → no DSLOT, no redirect; following entries issue normally with out_is_dslot=0.
- flush asserted in DSLOT on the same cycle as the delay-slot pop → queue cleared, redirect_valid stays 0. Reset mid-DSLOT → all reset values, no redirect.
